// File: rtl/lut_config_ctrl.sv
// -----------------------------------------------------------------------------
// lut_config_ctrl
//
// Sequencing and arbitration controller for one bit-writable LUT SRAM.
//
// Configuration path:
//   A serial bitstream is shifted into a shadow word, with the first bit
//   received ending up at index 0. The word is then applied to the SRAM
//   with a single block-load pulse (sram_cen).
//
// Runtime path:
//   Outside configuration, single-bit writes from two requesters are
//   arbitrated round-robin. Each accepted write is issued on the SRAM
//   write port in the following cycle.
//
// Output timing:
//   Every output except the two request readys comes from a flop. The
//   readys must answer in the same cycle as the request, so they are
//   combinational.
// -----------------------------------------------------------------------------
module lut_config_ctrl #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_SIZE  = 2 ** ADDR_BITS
) (
    input  logic                 cclk,
    input  logic                 rst,
    // configuration stream
    input  logic                 cfg_start,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    // runtime requester 0
    input  logic                 req0_valid,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic                 req0_data,
    output logic                 req0_ready,
    // runtime requester 1
    input  logic                 req1_valid,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic                 req1_data,
    output logic                 req1_ready,
    // SRAM side
    output logic                 sram_cen,
    output logic [MEM_SIZE-1:0]  sram_config_in,
    output logic                 sram_write_en,
    output logic [ADDR_BITS-1:0] sram_waddr,
    output logic                 sram_data_in
);

    // FSM encoding; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_LOAD  = 2'b10;

    // Value of the beat counter on the final bit of a bitstream.
    localparam logic [ADDR_BITS-1:0] CNT_LAST = ADDR_BITS'(MEM_SIZE - 1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [ADDR_BITS-1:0] cnt_r;
    logic [ADDR_BITS-1:0] cnt_nxt_s;
    logic [MEM_SIZE-1:0]  shadow_r;
    logic [MEM_SIZE-1:0]  shadow_nxt_s;

    // Decoded FSM flags, registered so the status outputs come from flops.
    logic                 busy_r;
    logic                 shift_r;
    logic                 load_r;

    // Runtime write arbitration and issue.
    logic                 last_grant_r;      // 1: requester 1 was granted last
    logic                 grant0_s;
    logic                 grant1_s;
    logic                 wen_r;
    logic [ADDR_BITS-1:0] waddr_r;
    logic                 wdata_r;

    // A configuration beat is accepted only while shifting.
    logic                 beat_s;

    assign beat_s = (state_r == ST_SHIFT) && cfg_valid;

    // -------------------------------------------------------------------------
    // Round-robin grant.
    //
    // The arbiter is open only in IDLE with no configuration request this
    // cycle; cfg_start wins over any same-cycle write. With both requesters
    // valid, the one not granted last time wins. Reset closes the arbiter
    // so that no ready is seen while rst is held.
    // -------------------------------------------------------------------------

    // Combinational grant decision feeding the ready outputs and the write
    // issue register.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst && (state_r == ST_IDLE) && !cfg_start) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_r;
                grant1_s = !last_grant_r;
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Configuration sequencing.
    //
    // The shadow word shifts in from the top, so after MEM_SIZE beats the
    // first bit lands at index 0. The shadow is not cleared when a new
    // configuration starts: the full bitstream overwrites every bit anyway.
    // -------------------------------------------------------------------------

    // Next-state, counter and shadow computation for the configuration FSM.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        shadow_nxt_s = shadow_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = {ADDR_BITS{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (beat_s) begin
                    shadow_nxt_s = {cfg_bit, shadow_r[MEM_SIZE-1:1]};
                    cnt_nxt_s    = cnt_r + ADDR_BITS'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    // gap in the stream: hold everything
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // Configuration FSM, beat counter and shadow word registers.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {ADDR_BITS{1'b0}};
            shadow_r <= {MEM_SIZE{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            shadow_r <= shadow_nxt_s;
        end
    end

    // Registered decode of the next state into the status/strobe outputs.
    always_ff @(posedge cclk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            shift_r <= 1'b0;
            load_r  <= 1'b0;
        end else begin
            busy_r  <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_LOAD);
            shift_r <= (state_nxt_s == ST_SHIFT);
            load_r  <= (state_nxt_s == ST_LOAD);
        end
    end

    // -------------------------------------------------------------------------
    // Write issue.
    //
    // An accepted request is presented to the SRAM for exactly the next
    // cycle. Address and data hold their last value while write_en is low.
    // A write accepted in the last IDLE cycle still issues during the first
    // SHIFT cycle. LOAD is far enough behind IDLE that cen and write_en
    // can never overlap.
    // -------------------------------------------------------------------------

    // Round-robin history and registered SRAM write port.
    always_ff @(posedge cclk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            wen_r        <= 1'b0;
            waddr_r      <= {ADDR_BITS{1'b0}};
            wdata_r      <= 1'b0;
        end else begin
            wen_r <= grant0_s || grant1_s;
            if (grant0_s) begin
                last_grant_r <= 1'b0;
                waddr_r      <= req0_addr;
                wdata_r      <= req0_data;
            end else if (grant1_s) begin
                last_grant_r <= 1'b1;
                waddr_r      <= req1_addr;
                wdata_r      <= req1_data;
            end else begin
                last_grant_r <= last_grant_r;
                waddr_r      <= waddr_r;
                wdata_r      <= wdata_r;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign cfg_ready      = shift_r;
    assign cfg_busy       = busy_r;
    assign cfg_done       = load_r;
    assign sram_cen       = load_r;
    assign sram_config_in = shadow_r;
    assign req0_ready     = grant0_s;
    assign req1_ready     = grant1_s;
    assign sram_write_en  = wen_r;
    assign sram_waddr     = waddr_r;
    assign sram_data_in   = wdata_r;

endmodule

// File: tb/tb_lut_config_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lut_config_ctrl.
//
// The bench contains a small behavioural model of the controller:
//   - a configuration phase: idle / collecting bits / loading;
//   - the list of bits received in the current pass;
//   - the round-robin history;
//   - the expected contents of an attached bit-writable SRAM.
//
// One compare task checks every DUT output, and the SRAM contents, against
// the model on every cycle. Hand-computed literal checks pin the model on
// the directed scenarios.
// -----------------------------------------------------------------------------
module tb_lut_config_ctrl;
    localparam int AB = 4;
    localparam int MS = 16;

    logic          cclk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0, cfg_bit = 1'b0, cfg_valid = 1'b0;
    logic          req0_valid = 1'b0, req0_data = 1'b0;
    logic          req1_valid = 1'b0, req1_data = 1'b0;
    logic [AB-1:0] req0_addr = '0, req1_addr = '0;
    logic          cfg_ready, cfg_busy, cfg_done, req0_ready, req1_ready;
    logic          sram_cen, sram_write_en, sram_data_in;
    logic [MS-1:0] sram_config_in;
    logic [AB-1:0] sram_waddr;

    lut_config_ctrl #(.ADDR_BITS(AB), .MEM_SIZE(MS)) dut (
        .cclk(cclk), .rst(rst),
        .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .sram_cen(sram_cen), .sram_config_in(sram_config_in),
        .sram_write_en(sram_write_en), .sram_waddr(sram_waddr),
        .sram_data_in(sram_data_in)
    );

    always #5 cclk = ~cclk;

    // Attached SRAM: block load on cen, single-bit write on write_en.
    logic [MS-1:0] sram_mem = '0;
    always @(posedge cclk) begin
        if (sram_cen) sram_mem <= sram_config_in;
        else if (sram_write_en) sram_mem[sram_waddr] <= sram_data_in;
    end

    // ---------------- behavioural model ----------------
    int            m_phase = 0;      // 0 idle, 1 collecting bits, 2 loading
    logic [MS-1:0] m_base = '0;      // shadow contents when this pass began
    bit            m_bits[$];        // bits received so far in this pass
    int            m_last = 1;       // requester granted most recently
    bit            m_wen = 0;
    logic [AB-1:0] m_waddr = '0;
    logic          m_wdata = 1'b0;
    logic [MS-1:0] exp_mem = '0;
    bit            m_init = 0;
    bit            m_took = 0;
    int            cycle = 0;
    int            cen_seen = 0;
    int            total = 0, bad = 0;

    // Shadow as the stream defines it: after n beats, received bit j sits
    // at index MS-n+j; the older contents have moved down by n places.
    function automatic logic [MS-1:0] model_shadow();
        logic [MS-1:0] v;
        int n;
        n = m_bits.size();
        for (int i = 0; i < MS; i++) begin
            if (i >= MS - n) v[i] = m_bits[i - (MS - n)];
            else             v[i] = m_base[i + n];
        end
        return v;
    endfunction

    // Who is granted under the current inputs.
    task automatic model_grant(output bit g0, output bit g1);
        g0 = 0;
        g1 = 0;
        if (!rst && m_phase == 0 && !cfg_start) begin
            if (req0_valid && req1_valid) begin
                if (m_last == 1) g0 = 1;
                else             g1 = 1;
            end else if (req0_valid) g0 = 1;
            else if (req1_valid)     g1 = 1;
        end
    endtask

    // Advance the model by one clock edge.
    task automatic model_update();
        bit g0, g1;
        model_grant(g0, g1);
        // The SRAM acts on what was presented before this edge.
        if (m_phase == 2)  exp_mem = model_shadow();
        else if (m_wen)    exp_mem[m_waddr] = m_wdata;
        m_took = 0;
        if (rst) begin
            m_phase = 0;
            m_base  = '0;
            m_bits.delete();
            m_last  = 1;
            m_wen   = 0;
            m_waddr = '0;
            m_wdata = 1'b0;
        end else begin
            if (g0 || g1) begin
                m_wen   = 1;
                m_waddr = g0 ? req0_addr : req1_addr;
                m_wdata = g0 ? req0_data : req1_data;
                m_last  = g0 ? 0 : 1;
            end else begin
                m_wen = 0;
            end
            case (m_phase)
                0: if (cfg_start) begin
                       m_base = model_shadow();
                       m_bits.delete();
                       m_phase = 1;
                   end
                1: if (cfg_valid) begin
                       m_bits.push_back(cfg_bit);
                       m_took = 1;
                       if (m_bits.size() == MS) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
        m_init = 1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Full per-cycle comparison of DUT outputs against the model.
    task automatic check_outputs();
        bit g0, g1;
        if (!m_init) return;
        model_grant(g0, g1);
        cmp("cfg_ready", cfg_ready, 32'(m_phase == 1));
        cmp("cfg_busy", cfg_busy, 32'(m_phase != 0));
        cmp("cfg_done", cfg_done, 32'(m_phase == 2));
        cmp("sram_cen", sram_cen, 32'(m_phase == 2));
        cmp("config_in", sram_config_in, 32'(model_shadow()));
        cmp("req0_ready", req0_ready, 32'(g0));
        cmp("req1_ready", req1_ready, 32'(g1));
        cmp("write_en", sram_write_en, 32'(m_wen));
        cmp("waddr", sram_waddr, 32'(m_waddr));
        cmp("data_in", sram_data_in, 32'(m_wdata));
        cmp("sram_mem", sram_mem, 32'(exp_mem));
        cmp("cen_wen_excl", 32'(sram_cen && sram_write_en), 32'd0);
        if (sram_cen) cen_seen++;
    endtask

    // Inputs are already set: compare, then advance one clock.
    task automatic tick();
        #1 check_outputs();
        @(posedge cclk);
        model_update();
        cycle++;
        #1;
    endtask

    // Full configuration with random cfg_valid gaps (gap_pct percent idle).
    task automatic run_config(input logic [MS-1:0] word, input int gap_pct);
        int start_c, idx, guard;
        cfg_start = 1'b1;
        #1 cmp("start_req0_ready", req0_ready, 32'd0);
        start_c = cycle;
        tick();
        cfg_start = 1'b0;
        cmp("start_busy", cfg_busy, 32'd1);
        idx = 0;
        guard = 0;
        while (idx < MS && guard < 400) begin
            cfg_valid = ($urandom_range(0, 99) >= gap_pct);
            cfg_bit   = word[idx];
            tick();
            if (m_took) idx++;
            guard++;
        end
        cfg_valid = 1'b0;
        cmp("cfg_timeout", 32'(guard >= 400), 32'd0);
        // This is the LOAD cycle.
        cmp("load_cen", sram_cen, 32'd1);
        cmp("load_done", cfg_done, 32'd1);
        cmp("load_word", sram_config_in, 32'(word));
        cmp("load_latency_ok", 32'((cycle - start_c + 1) >= MS + 2), 32'd1);
        tick();
        cmp("after_load_idle", cfg_busy, 32'd0);
    endtask

    initial begin
        logic [MS-1:0] w;
        int c0;

        // ---- reset with every input active ----
        rst = 1'b1;
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 1'b1; req1_data = 1'b1;
        req0_addr = 4'd6; req1_addr = 4'd10;
        tick();
        tick();
        cmp("rst_busy", cfg_busy, 32'd0);
        cmp("rst_cen", sram_cen, 32'd0);
        cmp("rst_wen", sram_write_en, 32'd0);
        cmp("rst_req0_ready", req0_ready, 32'd0);
        cmp("rst_config_in", sram_config_in, 32'd0);
        rst = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // ---- configuration of 16'hA5C3 with gaps ----
        w = 16'hA5C3;
        c0 = cen_seen;
        run_config(w, 35);
        cmp("cen_pulses_a5c3", 32'(cen_seen - c0), 32'd1);
        for (int a = 0; a < MS; a++) cmp("mem_a5c3_bit", sram_mem[a], w[a]);

        // ---- round robin, requester 0 first after reset ----
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 1'b1;
        req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 cmp("rr_grant0", req0_ready, 32'(i % 2 == 0));
            tick();
            cmp("rr_wen", sram_write_en, 32'd1);
            cmp("rr_waddr", sram_waddr, (i % 2 == 0) ? 32'd3 : 32'd9);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        cmp("rr_wen_drop", sram_write_en, 32'd0);

        // ---- cfg_start beats a same-cycle request ----
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 1'b0;
        run_config(16'h3C96, 20);
        cmp("prio_after_load", req0_ready, 32'd1);
        tick();
        req0_valid = 1'b0;
        cmp("prio_wen", sram_write_en, 32'd1);
        cmp("prio_waddr", sram_waddr, 32'd7);
        tick();

        // ---- reset after 7 beats ----
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cfg_bit = 1'($urandom_range(0, 1));
            tick();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        c0 = cen_seen;
        tick();
        rst = 1'b0;
        cmp("midrst_busy", cfg_busy, 32'd0);
        tick();
        cmp("midrst_no_cen", 32'(cen_seen - c0), 32'd0);
        cmp("midrst_mem_kept", sram_mem, 32'(16'h3C16));
        c0 = cen_seen;
        run_config(16'h1234, 0);
        cmp("midrst_one_load", 32'(cen_seen - c0), 32'd1);

        // ---- all-zero load then single write ----
        run_config(16'h0000, 30);
        req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 1'b1;
        #1 cmp("single_ready1", req1_ready, 32'd1);
        tick();
        req1_valid = 1'b0;
        cmp("single_wen", sram_write_en, 32'd1);
        cmp("single_waddr", sram_waddr, 32'd5);
        tick();
        cmp("single_mem", sram_mem, 32'(16'h0020));

        // ---- randomized traffic ----
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            cfg_start  = ($urandom_range(0, 24) == 0);
            cfg_valid  = ($urandom_range(0, 99) < 70);
            cfg_bit    = 1'($urandom_range(0, 1));
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_addr  = 4'($urandom_range(0, 15));
            req1_addr  = 4'($urandom_range(0, 15));
            req0_data  = 1'($urandom_range(0, 1));
            req1_data  = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 24; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lut_config_ctrl.md
Name: lut_config_ctrl

Overview:
Sequencing and arbitration controller for one bit-writable LUT SRAM. It assembles a serial configuration bitstream into a shadow word and applies it to the SRAM with a single block-load pulse. Outside configuration, it arbitrates single-bit runtime writes from two requesters onto the SRAM's dual-port write interface. It sits between the fabric configuration chain and the CLB's LUT storage.

Parameters:
ADDR_BITS, 4, LUT address width.
MEM_SIZE, 2**ADDR_BITS, LUT storage bits; must equal the attached SRAM's MEM_SIZE.

Ports:
cclk  in  1  configuration/fabric clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
cfg_start  in  1  request a full reconfiguration; honoured only in IDLE.
cfg_bit  in  1  serial configuration data bit.
cfg_valid  in  1  cfg_bit is valid this cycle.
cfg_ready  out  1  controller accepts cfg_bit this cycle.
cfg_busy  out  1  high whenever the FSM is not IDLE.
cfg_done  out  1  one-cycle pulse, coincident with sram_cen.
req0_valid  in  1  requester 0 bit-write request.
req0_addr  in  ADDR_BITS  requester 0 target bit address.
req0_data  in  1  requester 0 write value.
req0_ready  out  1  requester 0 request accepted this cycle.
req1_valid, req1_addr, req1_data, req1_ready  same widths and meaning for requester 1.
sram_cen  out  1  drives SRAM cen.
sram_config_in  out  MEM_SIZE  drives SRAM config_in; this is the shadow register.
sram_write_en  out  1  drives SRAM write_en.
sram_waddr  out  ADDR_BITS  drives SRAM waddr.
sram_data_in  out  1  drives SRAM data_in.

Behaviour:
- FSM states: IDLE, SHIFT, LOAD.
- IDLE -> SHIFT when cfg_start=1. The bit counter clears to 0.
- SHIFT:
  - cfg_ready=1.
  - Each beat with cfg_valid&&cfg_ready: shadow <= {cfg_bit, shadow[MEM_SIZE-1:1]}, and the counter increments.
  - After MEM_SIZE beats, the first bit received sits at index 0 and the last at index MEM_SIZE-1.
  - Gaps in cfg_valid stall the shift with no state change.
  - On the beat where counter==MEM_SIZE-1: go to LOAD.
- LOAD: lasts exactly one cycle. sram_cen=1 and cfg_done=1, then go to IDLE.
- cfg_ready=0 outside SHIFT. cfg_valid is ignored in IDLE and LOAD. cfg_start is ignored outside IDLE.
- cfg_busy = (state != IDLE).
- sram_config_in continuously reflects shadow; the SRAM samples it only when cen=1.
- Write arbitration (IDLE only, and only when cfg_start=0):
  - Round-robin between requesters, tracked by a last_grant register.
  - With both valid, grant the requester that is not last_grant. With one valid, grant it.
  - reqN_ready = grant to N; this is a combinational function of the valids, state, cfg_start and last_grant.
  - At most one reqN_ready is high per cycle. last_grant updates on each accepted request.
- cfg_start in IDLE beats any same-cycle request: both readys are 0 and the FSM moves to SHIFT.
- Write issue:
  - An accepted request at edge N registers sram_write_en=1, sram_waddr=addr and sram_data_in=data for the cycle after edge N.
  - sram_write_en is low in any cycle with no acceptance at the prior edge.
  - Throughput is one write per cycle.
  - sram_waddr and sram_data_in hold their last value when write_en=0.
- A write accepted in the last IDLE cycle still issues in the first SHIFT cycle.
- sram_cen and sram_write_en are never high in the same cycle, since LOAD occurs at least MEM_SIZE cycles after leaving IDLE.
- Reset (any state, including mid-SHIFT):
  - state=IDLE, counter=0, shadow=0, last_grant=1 (requester 0 wins first).
  - All outputs 0: cfg_ready, cfg_busy, cfg_done, req*_ready, sram_cen, sram_config_in, sram_write_en, sram_waddr, sram_data_in.
  - A partial bitstream is discarded and never loaded. The SRAM contents are not touched by reset.
- Latency: a full configuration takes at least MEM_SIZE+2 cycles from cfg_start to cfg_done (1 IDLE->SHIFT, MEM_SIZE beats, 1 LOAD).

Test Plan:
- Reset: hold rst 2 cycles with all inputs active -> every output 0, cfg_busy=0, no sram_cen or write_en pulse.
- Configuration: cfg_start, then 16 bits of 16'hA5C3 sent bit0-first with random cfg_valid gaps -> exactly one cycle of sram_cen=cfg_done=1 with sram_config_in=16'hA5C3; attached SRAM out matches for all 16 addresses.
- Round-robin: req0 (addr 3, data 1) and req1 (addr 9, data 0) held valid for 4 cycles -> grants 0,1,0,1; write_en high each following cycle, waddr 3,9,3,9.
- Config priority: cfg_start and req0_valid asserted in the same IDLE cycle -> req0_ready=0, cfg_busy=1 next cycle; req0 is accepted only in the first IDLE cycle after LOAD.
- Mid-config reset: rst after 7 of 16 beats -> IDLE, no sram_cen; a new cfg_start then needs a full 16 beats before cfg_done.
- Single write after config: load all zeros, then req1 addr 5 data 1 -> write_en next cycle with waddr=5; SRAM out at addr 5 =1, other addresses 0.
